sc_chip_emulator: RTL and testbench
===================================

# sc_chip_emulator

Chip-side scan-chain target model for FPGA loopback testing of the scan-chain master without silicon. It samples the master's `sc_clk` and `sc_data` pins, shifts a `SC_LEN`-bit chain, and drives `s_chipout` back to the master. It also latches the completed frame into a shadow configuration register, the way the radio chip does. It sits in the top level between the scan-chain master outputs and the `s_chipout` input, selected in place of the chip pads.

## Interface
- `SC_LEN`, 100: chain length in bits.
- `IDLE_TO`, 64: number of `clki` cycles with no `sc_clk` edge that ends a frame; minimum 8.
- `CNT_W`, 8: bit-counter width; must satisfy 2^CNT_W > SC_LEN.
- `clki` input 1: system clock, 100 MHz.
- `reset` input 1: synchronous, active-high reset.
- `sc_clk` input 1: scan clock from the master; asynchronous to `clki`.
- `sc_data` input 1: scan data from the master; asynchronous to `clki`.
- `status_in` input SC_LEN: parallel capture word. Used only with `SC_EMU_CAPTURE_EN`.
- `s_chipout` output 1: scan data returned to the master.
- `cfg_out` output SC_LEN: shadow configuration register.
- `cfg_valid` output 1: one-cycle pulse when `cfg_out` updates.
- `len_err` output 1: one-cycle pulse when a frame ends with bit count ≠ SC_LEN.
- `bit_cnt` output CNT_W: number of rising edges counted in the current or last frame.

## Operation
- Input synchronizers:
  - `sc_clk` and `sc_data` each pass through 2 flip-flops with identical depth, so the data stays aligned with the clock edge.
  - A third register on `sc_clk` provides edge detection: `rise` = sync & ~prev, `fall` = ~sync & prev.
- Shift register `sr[SC_LEN-1:0]`:
  - On `rise`: sr ← {sr[SC_LEN-2:0], synced sc_data}.
  - On `fall`: `s_chipout` ← sr[SC_LEN-1]. The output launches on the falling edge so the master can sample it on the next rising edge.
- FSM states are IDLE, SHIFT and DONE.
- IDLE:
  - `bit_cnt` holds its last value.
  - On `rise`, go to SHIFT. In the same cycle, `bit_cnt` ← 1 and the shift is performed.
- SHIFT:
  - Each `rise` shifts sr and increments `bit_cnt`. `bit_cnt` saturates at 2^CNT_W−1.
  - The idle counter clears on any `rise` or `fall`. Otherwise it increments.
  - When the idle counter reaches IDLE_TO−1, go to DONE.
- DONE (one cycle), then return to IDLE:
  - If `bit_cnt` == SC_LEN: `cfg_out` ← sr and `cfg_valid` = 1.
  - Otherwise: `cfg_out` is unchanged and `len_err` = 1.
- Long frames: with more than SC_LEN bits, sr holds the last SC_LEN bits received, and `len_err` fires.
- A `rise` in the DONE cycle is processed as the first bit of a new frame: shift, `bit_cnt` ← 1, and go to SHIFT. The DONE outputs still pulse.
- Reset:
  - All outputs and internal state are cleared: `sr`=0, `cfg_out`=0, `s_chipout`=0, `cfg_valid`=0, `len_err`=0, `bit_cnt`=0, FSM=IDLE, synchronizers=0.
  - Reset mid-frame discards the partial frame. No pulse is generated.

## Timing
- Edge latency: a pin edge on `sc_clk` is seen as `rise`/`fall` 3 `clki` cycles after it is launched (2 synchronizer stages plus the edge register).
- Output latency: `s_chipout` changes 1 cycle after `fall`, which is 4 cycles after the pin's falling edge.
- `sc_clk` high and low phases must each be ≥ 4 `clki` cycles. Shorter phases may be missed, and this is not detected.
- `sc_data` must be stable for ≥ 3 `clki` cycles around each rising edge of `sc_clk`.
- Frame-end latency: `cfg_valid`/`len_err` pulse IDLE_TO+1 cycles after the last detected edge of `sc_clk`.
- Loopback property: the bit presented at shift n appears on `s_chipout` after the falling edge of shift n+SC_LEN−1. A full chain returns the previous contents of sr.

## Configuration
- `SC_EMU_CAPTURE_EN` defined:
  - In IDLE, every cycle: sr ← `status_in` and `s_chipout` ← `status_in[SC_LEN-1]`.
  - A frame therefore reads back `status_in`, with MSB first.
- `SC_EMU_CAPTURE_EN` undefined:
  - `status_in` is ignored.
  - sr keeps its contents between frames, so a frame reads back the previous frame's last SC_LEN bits.

## Test plan
- Reset, then 100 rises of `sc_clk` shifting 100'h5_A5A5_A5A5_A5A5_A5A5_A5A5_A5A5 (MSB first), then ≥ 64 idle cycles:
  - `cfg_out` equals that pattern.
  - One `cfg_valid` pulse; `bit_cnt`=100; `len_err` stays 0.
- Second 100-bit frame of all ones, macro undefined:
  - The `s_chipout` bits sampled on rises return the first pattern, MSB first.
  - `cfg_out` becomes all ones.
- Frame of 99 bits, then idle:
  - `len_err` pulses once; `bit_cnt`=99.
  - `cfg_out` keeps its prior value; no `cfg_valid` pulse.
- Frame of 105 bits:
  - `len_err` pulses; `bit_cnt`=105.
  - sr holds the last 100 bits; `cfg_out` unchanged.
- Assert `reset` after 50 bits, then send a full 100-bit frame of 100'h1:
  - All outputs are 0 after reset.
  - `cfg_out`=100'h1 and exactly one `cfg_valid` pulse.
- `SC_EMU_CAPTURE_EN` defined, `status_in`=100'hC_0000_0000_0000_0000_0000_0003, send a 100-bit frame:
  - `s_chipout` returns 1,1,0…0,1,1.
  - `cfg_out` equals the shifted-in data.

Source files
------------

// File: rtl/sc_chip_emulator_if.sv
`default_nettype none
// ============================================================================
//  Module      : sc_chip_emulator_if
//  Description : Scan-chain pin bundle between a scan-chain master and the
//                chip-side target. The master drives sc_clk/sc_data and
//                samples s_chipout; the slave (chip model) does the reverse.
//  Signals     : sc_clk    - scan clock (master -> chip)
//                sc_data   - scan data  (master -> chip)
//                s_chipout - scan data returned (chip -> master)
//  Revision    : 1.0 - initial release
// ============================================================================
interface sc_chip_emulator_if;
    logic sc_clk;
    logic sc_data;
    logic s_chipout;

    modport master (
        output sc_clk,
        output sc_data,
        input  s_chipout
    );

    modport slave (
        input  sc_clk,
        input  sc_data,
        output s_chipout
    );
endinterface
`default_nettype wire

// File: rtl/sc_chip_emulator.sv
`default_nettype none
// ============================================================================
//  Module      : sc_chip_emulator
//  Description : Chip-side scan-chain target used for FPGA loopback of the
//                scan-chain master. Oversamples sc_clk/sc_data on clki,
//                shifts an SC_LEN-bit chain on sc_clk rising edges, returns
//                the chain MSB on s_chipout at sc_clk falling edges, and
//                latches a complete frame into a shadow config register once
//                sc_clk has been quiet for IDLE_TO cycles.
//  Ports       : clki      - system clock
//                reset     - synchronous active-high reset
//                sc_bus    - scan pins (slave modport)
//                status_in - parallel capture word (capture build only)
//                cfg_out   - shadow configuration register
//                cfg_valid - 1-cycle pulse, frame had exactly SC_LEN bits
//                len_err   - 1-cycle pulse, frame length was wrong
//                bit_cnt   - rising edges counted in current/last frame
//  Build macro : SC_EMU_CAPTURE_EN - when defined, the chain reloads from
//                status_in on every idle cycle so a frame reads it back.
//  Revision    : 1.0 - initial release
// ============================================================================
module sc_chip_emulator #(
    parameter int SC_LEN  = 100,
    parameter int IDLE_TO = 64,
    parameter int CNT_W   = 8
) (
    input  wire logic               clki,
    input  wire logic               reset,
    sc_chip_emulator_if.slave       sc_bus,
    input  wire logic [SC_LEN-1:0]  status_in,
    output logic      [SC_LEN-1:0]  cfg_out,
    output logic                    cfg_valid,
    output logic                    len_err,
    output logic      [CNT_W-1:0]   bit_cnt
);

    localparam int                  c_idle_w    = $clog2(IDLE_TO);
    localparam logic [c_idle_w-1:0] c_idle_last = c_idle_w'(IDLE_TO - 1);
    localparam logic [CNT_W-1:0]    c_len_cnt   = CNT_W'(SC_LEN);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;

    // Clock and data share the same synchronizer depth so the sampled data
    // bit lines up with the detected clock edge.
    logic                r_clk_s1;
    logic                r_clk_s2;
    logic                r_clk_prev;
    logic                r_dat_s1;
    logic                r_dat_s2;

    logic [SC_LEN-1:0]   r_sr;
    logic [SC_LEN-1:0]   r_cfg;
    logic                r_chipout;
    logic [CNT_W-1:0]    r_bit_cnt;
    logic [c_idle_w-1:0] r_idle_cnt;

    logic                w_rise;
    logic                w_fall;
    logic                w_cnt_first;
    logic                w_cnt_inc;
    logic                w_idle_inc;
    logic                w_cfg_load;
    logic                w_len_err;

    assign w_rise = r_clk_s2 & ~r_clk_prev;
    assign w_fall = ~r_clk_s2 & r_clk_prev;

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clki) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM next state and control strobes
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_first = 1'b0;
        w_cnt_inc   = 1'b0;
        w_idle_inc  = 1'b0;
        w_cfg_load  = 1'b0;
        w_len_err   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_rise) begin
                    w_state_nxt = ST_SHIFT;
                    w_cnt_first = 1'b1;
                end
            end
            ST_SHIFT: begin
                if (w_rise) begin
                    w_cnt_inc = 1'b1;
                end
                // Any sc_clk activity keeps the frame open; the idle
                // counter is cleared whenever w_idle_inc stays low.
                if (!(w_rise || w_fall)) begin
                    if (r_idle_cnt == c_idle_last) begin
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_idle_inc = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                if (r_bit_cnt == c_len_cnt) begin
                    w_cfg_load = 1'b1;
                end else begin
                    w_len_err = 1'b1;
                end
                // A rise landing here already belongs to the next frame.
                if (w_rise) begin
                    w_state_nxt = ST_SHIFT;
                    w_cnt_first = 1'b1;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Synchronizers, counters, chain and shadow register
    // ------------------------------------------------------------------
    always_ff @(posedge clki) begin
        if (reset) begin
            r_clk_s1   <= 1'b0;
            r_clk_s2   <= 1'b0;
            r_clk_prev <= 1'b0;
            r_dat_s1   <= 1'b0;
            r_dat_s2   <= 1'b0;
            r_sr       <= '0;
            r_cfg      <= '0;
            r_chipout  <= 1'b0;
            r_bit_cnt  <= '0;
            r_idle_cnt <= '0;
        end else begin
            r_clk_s1   <= sc_bus.sc_clk;
            r_clk_s2   <= r_clk_s1;
            r_clk_prev <= r_clk_s2;
            r_dat_s1   <= sc_bus.sc_data;
            r_dat_s2   <= r_dat_s1;

            if (w_idle_inc) begin
                r_idle_cnt <= r_idle_cnt + 1'b1;
            end else begin
                r_idle_cnt <= '0;
            end

            if (w_cnt_first) begin
                r_bit_cnt <= CNT_W'(1);
            end else if (w_cnt_inc && (r_bit_cnt != {CNT_W{1'b1}})) begin
                r_bit_cnt <= r_bit_cnt + 1'b1;
            end

            if (w_cfg_load) begin
                r_cfg <= r_sr;
            end

            if (w_rise) begin
                r_sr <= {r_sr[SC_LEN-2:0], r_dat_s2};
            end
`ifdef SC_EMU_CAPTURE_EN
            else if (r_state == ST_IDLE) begin
                r_sr <= status_in;
            end
`endif

            // Launch on the falling edge so the master samples it on the
            // following rising edge.
            if (w_fall) begin
                r_chipout <= r_sr[SC_LEN-1];
            end
`ifdef SC_EMU_CAPTURE_EN
            else if (r_state == ST_IDLE) begin
                r_chipout <= status_in[SC_LEN-1];
            end
`endif
        end
    end

`ifndef SC_EMU_CAPTURE_EN
    // status_in has no function in this build.
    logic w_unused_status;
    assign w_unused_status = ^status_in;
`endif

    assign sc_bus.s_chipout = r_chipout;
    assign cfg_out          = r_cfg;
    assign cfg_valid        = w_cfg_load;
    assign len_err          = w_len_err;
    assign bit_cnt          = r_bit_cnt;

endmodule
`default_nettype wire

// File: tb/tb_sc_chip_emulator.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sc_chip_emulator
//  Description : Self-checking bench for sc_chip_emulator. Acts as the scan
//                master, sends directed and random frames, and compares the
//                DUT against a frame-level model: readback bit k of a frame
//                is the chain content from before the frame (or the bit sent
//                SC_LEN rises earlier), frame ends yield exactly one pulse of
//                the right kind, cfg_out follows only complete frames.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sc_chip_emulator;

    localparam int SC_LEN  = 100;
    localparam int IDLE_TO = 64;
    localparam int CNT_W   = 8;

    localparam logic [SC_LEN-1:0] c_pat  = 100'h5_A5A5_A5A5_A5A5_A5A5_A5A5_A5A5;
    localparam logic [SC_LEN-1:0] c_ones = {SC_LEN{1'b1}};
    localparam logic [SC_LEN-1:0] c_one  = 100'h1;

    logic              clki = 1'b0;
    logic              reset;
    logic [SC_LEN-1:0] status_in;
    logic [SC_LEN-1:0] cfg_out;
    logic              cfg_valid;
    logic              len_err;
    logic [CNT_W-1:0]  bit_cnt;

    sc_chip_emulator_if sc_bus ();

    sc_chip_emulator #(
        .SC_LEN  (SC_LEN),
        .IDLE_TO (IDLE_TO),
        .CNT_W   (CNT_W)
    ) dut (
        .clki      (clki),
        .reset     (reset),
        .sc_bus    (sc_bus),
        .status_in (status_in),
        .cfg_out   (cfg_out),
        .cfg_valid (cfg_valid),
        .len_err   (len_err),
        .bit_cnt   (bit_cnt)
    );

    always #5 clki = ~clki;

    int cyc = 0;
    always @(posedge clki) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    // Model state
    logic [SC_LEN-1:0] m_chain;      // last SC_LEN bits received
    logic [SC_LEN-1:0] exp_cfg_old;
    logic [SC_LEN-1:0] exp_cfg_new;
    logic [1:0]        exp_kind;     // {cfg_valid, len_err}
    int                exp_cnt;
    int                win_lo = -10;
    int                win_hi = -10;
    int                n_pulse;
    bit                chk_en = 1'b0;
    bit                in_win;
    logic [127:0]      rb;           // bits sampled on s_chipout, MSB first

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual %h required %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clki);
        #1;
    endtask

    // Per-cycle compare: outside the frame-end window nothing may pulse and
    // cfg_out must hold; inside, any pulse must be of the expected kind.
    always @(negedge clki) begin
        if (chk_en) begin
            in_win = (cyc >= win_lo) && (cyc <= win_hi);
            if (!in_win) begin
                chk("no_stray_pulse", {cfg_valid, len_err}, 2'b00);
                chk("cfg_out", cfg_out, (cyc > win_hi) ? exp_cfg_new : exp_cfg_old);
            end else if (cfg_valid || len_err) begin
                n_pulse++;
                chk("end_pulse_kind", {cfg_valid, len_err}, exp_kind);
                chk("end_bit_cnt", bit_cnt, exp_cnt);
            end
        end
    end

    // Send n bits, data[n-1] first. With abort set the frame is left open.
    task automatic send_frame(input int n, input logic [127:0] data, input bit abort);
        logic [SC_LEN-1:0] base;
        logic              b;
        logic              exp_b;
        int                last_fall;
`ifdef SC_EMU_CAPTURE_EN
        base = status_in;
`else
        base = m_chain;
`endif
        rb = '0;
        last_fall = cyc;
        for (int k = 1; k <= n; k++) begin
            b = data[n-k];
            sc_bus.sc_data = b;
            tick($urandom_range(5, 8));
            exp_b = (k <= SC_LEN) ? base[SC_LEN-k] : data[n-(k-SC_LEN)];
            chk("chipout_readback", sc_bus.s_chipout, exp_b);
            rb = {rb[126:0], sc_bus.s_chipout};
            sc_bus.sc_clk = 1'b1;
            tick($urandom_range(4, 8));
            sc_bus.sc_clk = 1'b0;
            last_fall = cyc;
            m_chain = {m_chain[SC_LEN-2:0], b};
        end
        if (!abort) begin
            n_pulse  = 0;
            exp_cnt  = (n > 255) ? 255 : n;
            exp_kind = (n == SC_LEN) ? 2'b10 : 2'b01;
            win_lo   = last_fall + IDLE_TO + 2;
            win_hi   = last_fall + IDLE_TO + 6;
            exp_cfg_old = exp_cfg_new;
            if (n == SC_LEN) exp_cfg_new = m_chain;
            tick(IDLE_TO + 12);
            chk("pulse_count", n_pulse, 1);
            chk("bit_cnt_hold", bit_cnt, exp_cnt);
        end
    endtask

    task automatic do_reset();
        chk_en = 1'b0;
        reset  = 1'b1;
        tick(3);
        reset  = 1'b0;
        chk("rst_cfg_out", cfg_out, '0);
        chk("rst_cfg_valid", cfg_valid, 1'b0);
        chk("rst_len_err", len_err, 1'b0);
        chk("rst_bit_cnt", bit_cnt, '0);
        chk("rst_chipout", sc_bus.s_chipout, 1'b0);
        m_chain     = '0;
        exp_cfg_old = '0;
        exp_cfg_new = '0;
        win_lo      = -10;
        win_hi      = -10;
        chk_en      = 1'b1;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: run did not complete in time");
        n_errors++;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $fatal(1);
    end

    initial begin
        logic [127:0] rnd;
        int           len;
        sc_bus.sc_clk  = 1'b0;
        sc_bus.sc_data = 1'b0;
        status_in      = '0;
        reset          = 1'b1;
        tick(2);
        do_reset();
        tick(4);

        // Frame 1: reference pattern
        send_frame(SC_LEN, {28'h0, c_pat}, 1'b0);
        chk("lit_cfg_pattern", cfg_out, c_pat);
        chk("lit_bit_cnt_100", bit_cnt, 8'd100);

        // Frame 2: all ones, reads back frame 1
        send_frame(SC_LEN, {28'h0, c_ones}, 1'b0);
`ifndef SC_EMU_CAPTURE_EN
        chk("lit_readback_pattern", rb[SC_LEN-1:0], c_pat);
`endif
        chk("lit_cfg_ones", cfg_out, c_ones);

        // Short frame
        rnd = {$urandom, $urandom, $urandom, $urandom};
        send_frame(99, rnd, 1'b0);
        chk("lit_bit_cnt_99", bit_cnt, 8'd99);
        chk("lit_cfg_kept_99", cfg_out, c_ones);

        // Long frame
        rnd = {$urandom, $urandom, $urandom, $urandom};
        send_frame(105, rnd, 1'b0);
        chk("lit_bit_cnt_105", bit_cnt, 8'd105);
        chk("lit_cfg_kept_105", cfg_out, c_ones);

        // Reset mid-frame, then a clean frame of 1
        rnd = {$urandom, $urandom, $urandom, $urandom};
        send_frame(50, rnd, 1'b1);
        tick(2);
        do_reset();
        tick(4);
        send_frame(SC_LEN, {28'h0, c_one}, 1'b0);
        chk("lit_cfg_one", cfg_out, c_one);

`ifdef SC_EMU_CAPTURE_EN
        status_in = 100'hC_0000_0000_0000_0000_0000_0003;
        tick(4);
        rnd = {$urandom, $urandom, $urandom, $urandom};
        send_frame(SC_LEN, rnd, 1'b0);
        chk("lit_capture_readback", rb[SC_LEN-1:0], 100'hC_0000_0000_0000_0000_0000_0003);
        chk("lit_capture_cfg", cfg_out, rnd[SC_LEN-1:0]);
`endif

        // Random frames around the nominal length
        for (int i = 0; i < 6; i++) begin
            status_in = {$urandom, $urandom, $urandom, $urandom};
            tick(3);
            len = $urandom_range(98, 102);
            rnd = {$urandom, $urandom, $urandom, $urandom};
            send_frame(len, rnd, 1'b0);
        end

        tick(5);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
